// File: rtl/disp_pkg.sv
// Shared definitions for the display mode controller.
// Holds the mode and field encodings, digit geometry, and the per-field blank
// masks used while a time-of-day field is being edited.
package disp_pkg;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 6;
  localparam int DIGITS_W   = BCD_W * NUM_DIGITS;

  typedef enum logic [1:0] {
    MODE_TOD = 2'b00,
    MODE_SW  = 2'b01,
    MODE_AL  = 2'b10,
    MODE_SET = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    FLD_HR  = 2'b00,
    FLD_MIN = 2'b01,
    FLD_SEC = 2'b10
  } field_e;

  localparam logic [NUM_DIGITS-1:0] MASK_HR  = 6'b110000;
  localparam logic [NUM_DIGITS-1:0] MASK_MIN = 6'b001100;
  localparam logic [NUM_DIGITS-1:0] MASK_SEC = 6'b000011;

  // Digits belonging to the field under edit.
  function automatic logic [NUM_DIGITS-1:0] field_mask(input field_e f);
    case (f)
      FLD_HR:  return MASK_HR;
      FLD_MIN: return MASK_MIN;
      FLD_SEC: return MASK_SEC;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level counter and
// press-pulse generator for one active-low key.
// Ports:
//   clk      - scan clock
//   rst_n    - asynchronous active-low reset (key treated as released)
//   i_key_n  - raw active-low key level
//   o_press  - one-clk pulse when the accepted level falls 1->0
module key_debounce
  import disp_pkg::*;
#(
  parameter int DB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_acc   <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_meta  <= i_key_n;
      r_sync  <= r_meta;
      r_press <= 1'b0;
      if (r_sync == r_acc) begin
        // Any return to the accepted level restarts the stability count.
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_acc <= r_sync;
        // Levels differ here, so an accepted level of 1 means a falling edge.
        r_press <= r_acc;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/display_mode_ctrl.sv
// Display scheduler in front of the 6-digit scan/print driver.
// Selects the digit source shown (time-of-day, stopwatch, alarm) and runs the
// time-of-day set mode: two debounced keys, field selection, increment pulses
// and blinking of the field under edit.
// Ports:
//   clk, rst_n            - 1 kHz scan clock, asynchronous active-low reset
//   key_mode_n, key_sel_n - raw active-low MODE / SEL buttons
//   tick_half             - 2 Hz one-clk pulse, blink and timeout timebase
//   tod/sw/al_digits      - 6 BCD digits per source, digit 0 in [3:0]
//   out_digits            - registered selected digits
//   blank_mask            - registered per-digit blank (1 = off)
//   mode                  - 00 TOD, 01 SW, 10 AL, 11 SET_TOD
//   set_field             - 00 hours, 01 minutes, 10 seconds
//   inc_pulse             - one-clk increment request for set_field
module display_mode_ctrl
  import disp_pkg::*;
#(
  parameter int DB_CYCLES     = 20,
  parameter int TIMEOUT_HALFS = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_mode_n,
  input  logic                  key_sel_n,
  input  logic                  tick_half,
  input  logic [DIGITS_W-1:0]   tod_digits,
  input  logic [DIGITS_W-1:0]   sw_digits,
  input  logic [DIGITS_W-1:0]   al_digits,
  output logic [DIGITS_W-1:0]   out_digits,
  output logic [NUM_DIGITS-1:0] blank_mask,
  output logic [1:0]            mode,
  output logic [1:0]            set_field,
  output logic                  inc_pulse
);

  localparam int TO_W = (TIMEOUT_HALFS > 1) ? $clog2(TIMEOUT_HALFS) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_HALFS - 1);

  logic w_mode_press;
  logic w_sel_press;
  logic w_mode_ev;
  logic w_sel_ev;
  logic w_clr_phase;

  mode_e     r_mode,  w_nxt_mode;
  field_e    r_field, w_nxt_field;
  logic      r_inc,   w_nxt_inc;
  logic      r_phase, w_nxt_phase;
  logic [TO_W-1:0] r_to, w_nxt_to;

  logic [DIGITS_W-1:0]   r_out;
  logic [NUM_DIGITS-1:0] r_blank;
  logic [DIGITS_W-1:0]   w_src;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_mode_n),
    .o_press (w_mode_press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_sel_n),
    .o_press (w_sel_press)
  );

  // SEL wins a same-cycle collision; the MODE event is discarded.
  assign w_sel_ev  = w_sel_press;
  assign w_mode_ev = w_mode_press & ~w_sel_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= MODE_TOD;
      r_field <= FLD_HR;
      r_inc   <= 1'b0;
      r_phase <= 1'b0;
      r_to    <= '0;
    end else begin
      r_mode  <= w_nxt_mode;
      r_field <= w_nxt_field;
      r_inc   <= w_nxt_inc;
      r_phase <= w_nxt_phase;
      r_to    <= w_nxt_to;
    end
  end

  always_comb begin
    w_nxt_mode  = r_mode;
    w_nxt_field = r_field;
    w_nxt_inc   = 1'b0;
    w_nxt_phase = r_phase;
    w_nxt_to    = r_to;
    w_clr_phase = 1'b0;

    case (r_mode)
      MODE_TOD: begin
        if (w_sel_ev) begin
          w_nxt_mode  = MODE_SET;
          w_nxt_field = FLD_HR;
        end else if (w_mode_ev) begin
          w_nxt_mode = MODE_SW;
        end
      end
      MODE_SW: begin
        if (w_mode_ev) w_nxt_mode = MODE_AL;
      end
      MODE_AL: begin
        if (w_mode_ev) w_nxt_mode = MODE_TOD;
      end
      MODE_SET: begin
        if (w_sel_ev) begin
          w_clr_phase = 1'b1;
          w_nxt_to    = '0;
          case (r_field)
            FLD_HR:  w_nxt_field = FLD_MIN;
            FLD_MIN: w_nxt_field = FLD_SEC;
            default: begin
              w_nxt_mode  = MODE_TOD;
              w_nxt_field = FLD_HR;
            end
          endcase
        end else if (w_mode_ev) begin
          w_nxt_inc   = 1'b1;
          w_clr_phase = 1'b1;
          w_nxt_to    = '0;
        end else if (tick_half) begin
          if (r_to == TO_LAST) begin
            w_nxt_mode  = MODE_TOD;
            w_nxt_field = FLD_HR;
          end else begin
            w_nxt_to = r_to + 1'b1;
          end
        end
      end
    endcase

    // Blink phase only runs while staying in SET_TOD; entry, field change and
    // increment all restart it visible, overriding a coincident tick.
    if ((w_nxt_mode != MODE_SET) || (r_mode != MODE_SET) || w_clr_phase) begin
      w_nxt_phase = 1'b0;
    end else if (tick_half) begin
      w_nxt_phase = ~r_phase;
    end

    if (w_nxt_mode != MODE_SET) begin
      w_nxt_to = '0;
    end
  end

  always_comb begin
    case (r_mode)
      MODE_SW: w_src = sw_digits;
      MODE_AL: w_src = al_digits;
      default: w_src = tod_digits;
    endcase
  end

  // Display outputs are registered from the current state, so they trail a
  // mode change by one cycle and no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_blank <= '0;
    end else begin
      r_out   <= w_src;
      r_blank <= ((r_mode == MODE_SET) && r_phase) ? field_mask(r_field) : '0;
    end
  end

  assign out_digits = r_out;
  assign blank_mask = r_blank;
  assign mode       = r_mode;
  assign set_field  = r_field;
  assign inc_pulse  = r_inc;

endmodule

// File: tb/tb_display_mode_ctrl.sv
module tb_display_mode_ctrl;

  localparam int DB = 20;
  localparam int TO = 20;

  localparam logic [23:0] TOD = 24'h123456;
  localparam logic [23:0] SW  = 24'h654321;
  localparam logic [23:0] AL  = 24'h070000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_mode_n;
  logic        key_sel_n;
  logic        tick_half;
  logic [23:0] tod_digits, sw_digits, al_digits;
  logic [23:0] out_digits;
  logic [5:0]  blank_mask;
  logic [1:0]  mode;
  logic [1:0]  set_field;
  logic        inc_pulse;

  int n_chk  = 0;
  int n_pass = 0;
  int inc_cnt = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  display_mode_ctrl #(.DB_CYCLES(DB), .TIMEOUT_HALFS(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_mode_n (key_mode_n),
    .key_sel_n  (key_sel_n),
    .tick_half  (tick_half),
    .tod_digits (tod_digits),
    .sw_digits  (sw_digits),
    .al_digits  (al_digits),
    .out_digits (out_digits),
    .blank_mask (blank_mask),
    .mode       (mode),
    .set_field  (set_field),
    .inc_pulse  (inc_pulse)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] field;
    logic       inc;
    logic       phase;
    logic [7:0] to;
  } mstate_t;

  logic [DB:0] h_mode, h_sel;   // bit k = raw level sampled k edges ago
  logic        a_mode, a_sel;   // accepted levels
  logic        e_mode, e_sel;   // press events visible this cycle
  mstate_t     ms;
  logic [23:0] m_out;
  logic [5:0]  m_blank;

  // A key level is accepted once the synchronized samples (two edges late)
  // have all shown the other level for DB consecutive edges.
  function automatic logic settled(input logic [DB:0] h, input logic acc);
    return acc ? (h[DB:1] == '0) : (h[DB:1] == '1);
  endfunction

  function automatic logic [5:0] fmask(input logic [1:0] f);
    return (f == 2'd0) ? 6'b110000 : (f == 2'd1) ? 6'b001100 : 6'b000011;
  endfunction

  function automatic logic [23:0] pick(input logic [1:0] m);
    return (m == 2'd1) ? sw_digits : (m == 2'd2) ? al_digits : tod_digits;
  endfunction

  function automatic mstate_t fsm_next(input mstate_t s, input logic ev_m_raw,
                                       input logic ev_s, input logic tick);
    mstate_t n;
    logic    ev_m;
    n     = s;
    n.inc = 1'b0;
    ev_m  = ev_m_raw & ~ev_s;
    if (s.mode != 2'd3) begin
      if (ev_s) begin
        n.mode  = 2'd3;
        n.field = 2'd0;
      end else if (ev_m) begin
        n.mode = (s.mode == 2'd2) ? 2'd0 : s.mode + 2'd1;
      end
      n.phase = 1'b0;
      n.to    = 8'd0;
    end else begin
      if (ev_s) begin
        if (s.field == 2'd2) begin
          n.mode  = 2'd0;
          n.field = 2'd0;
        end else begin
          n.field = s.field + 2'd1;
        end
      end else if (ev_m) begin
        n.inc = 1'b1;
      end
      if (ev_s | ev_m) begin
        n.to    = 8'd0;
        n.phase = 1'b0;
      end else if (tick) begin
        n.to    = s.to + 8'd1;
        n.phase = ~s.phase;
        if (n.to == 8'(TO)) begin
          n.mode  = 2'd0;
          n.field = 2'd0;
        end
      end
      if (n.mode != 2'd3) begin
        n.phase = 1'b0;
        n.to    = 8'd0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_mode  <= '1;
      h_sel   <= '1;
      a_mode  <= 1'b1;
      a_sel   <= 1'b1;
      e_mode  <= 1'b0;
      e_sel   <= 1'b0;
      ms      <= '0;
      m_out   <= '0;
      m_blank <= '0;
    end else begin
      h_mode  <= {h_mode[DB-1:0], key_mode_n};
      h_sel   <= {h_sel[DB-1:0], key_sel_n};
      a_mode  <= a_mode ^ settled(h_mode, a_mode);
      a_sel   <= a_sel ^ settled(h_sel, a_sel);
      e_mode  <= settled(h_mode, a_mode) & a_mode;
      e_sel   <= settled(h_sel, a_sel) & a_sel;
      ms      <= fsm_next(ms, e_mode, e_sel, tick_half);
      m_out   <= pick(ms.mode);
      m_blank <= ((ms.mode == 2'd3) && ms.phase) ? fmask(ms.field) : 6'b0;
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        n_chk++;
        if (mode === ms.mode && set_field === ms.field && inc_pulse === ms.inc &&
            out_digits === m_out && blank_mask === m_blank) begin
          n_pass++;
        end else begin
          $display("FAIL cycle_cmp t=%0t got mode=%0d fld=%0d inc=%0b out=%h blank=%b want mode=%0d fld=%0d inc=%0b out=%h blank=%b",
                   $time, mode, set_field, inc_pulse, out_digits, blank_mask,
                   ms.mode, ms.field, ms.inc, m_out, m_blank);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (inc_pulse === 1'b1) inc_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %h want %h", nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input bit k_mode, input bit k_sel);
    if (k_mode) key_mode_n = 1'b0;
    if (k_sel)  key_sel_n  = 1'b0;
    step(25);
    key_mode_n = 1'b1;
    key_sel_n  = 1'b1;
    step(25);
  endtask

  task automatic tick();
    tick_half = 1'b1;
    step(1);
    tick_half = 1'b0;
  endtask

  initial begin
    int c;
    int inc0;
    bit got;
    rst_n      = 1'b0;
    key_mode_n = 1'b1;
    key_sel_n  = 1'b1;
    tick_half  = 1'b0;
    tod_digits = TOD;
    sw_digits  = SW;
    al_digits  = AL;
    step(2);
    cmp_en = 1'b1;
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_out", 32'(out_digits), 32'd0);
    chk("rst_blank_inc", {25'd0, blank_mask, inc_pulse}, 32'd0);
    rst_n = 1'b1;
    step(2);
    chk("out_tod", 32'(out_digits), 32'(TOD));

    // Mode rotation with source following.
    press(1, 0);
    chk("mode_sw", 32'(mode), 32'd1);
    chk("out_sw", 32'(out_digits), 32'(SW));
    press(1, 0);
    chk("mode_al", 32'(mode), 32'd2);
    chk("out_al", 32'(out_digits), 32'(AL));
    press(1, 0);
    chk("mode_tod", 32'(mode), 32'd0);
    chk("out_tod2", 32'(out_digits), 32'(TOD));

    // Bounce: toggles every 5 cycles for 100 cycles, then stable low.
    for (int i = 0; i < 20; i++) begin
      key_mode_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(5);
    end
    key_mode_n = 1'b0;
    c = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (mode != 2'd0) begin
        c = i;
        break;
      end
    end
    chk("bounce_latency", 32'(c), 32'(DB + 3));
    chk("bounce_one_event", 32'(mode), 32'd1);
    key_mode_n = 1'b1;
    step(25);
    press(1, 0);
    press(1, 0);
    chk("back_tod", 32'(mode), 32'd0);

    // Enter set mode, two increments.
    press(0, 1);
    chk("set_entry", {30'd0, mode}, 32'd3);
    chk("set_field_hr", 32'(set_field), 32'd0);
    inc0 = inc_cnt;
    press(1, 0);
    press(1, 0);
    chk("two_incs", 32'(inc_cnt - inc0), 32'd2);

    // Minutes field blink, then increment while blanked.
    press(0, 1);
    chk("field_min", 32'(set_field), 32'd1);
    tick();
    step(1);
    chk("blink_on", 32'(blank_mask), 32'b001100);
    tick();
    step(1);
    chk("blink_off", 32'(blank_mask), 32'd0);
    tick();
    step(1);
    chk("blink_on2", 32'(blank_mask), 32'b001100);
    key_mode_n = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (inc_pulse) begin
        got = 1'b1;
        break;
      end
    end
    chk("inc_seen", 32'(got), 32'd1);
    chk("blank_at_inc", 32'(blank_mask), 32'b001100);
    step(1);
    chk("blank_after_inc", 32'(blank_mask), 32'd0);
    chk("inc_single", 32'(inc_pulse), 32'd0);
    key_mode_n = 1'b1;
    step(25);

    press(0, 1);
    chk("field_sec", 32'(set_field), 32'd2);
    press(0, 1);
    chk("sel_exit", 32'(mode), 32'd0);

    // Timeout after TO half-ticks.
    press(0, 1);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      step(1);
    end
    chk("to_19_still_set", 32'(mode), 32'd3);
    tick();
    chk("to_exit", 32'(mode), 32'd0);
    step(1);

    // Key event clears the timeout count.
    press(0, 1);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      step(1);
    end
    press(0, 1);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      step(1);
    end
    chk("to_cleared", 32'(mode), 32'd3);
    tick();
    chk("to_exit2", 32'(mode), 32'd0);
    step(1);

    // Simultaneous MODE and SEL in SHOW_TOD.
    press(1, 1);
    chk("simul_mode", 32'(mode), 32'd3);
    chk("simul_field", 32'(set_field), 32'd0);

    // Reset while an increment is about to be issued.
    inc0 = inc_cnt;
    key_mode_n = 1'b0;
    step(DB + 2);
    rst_n = 1'b0;
    #1;
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_field_inc", {29'd0, set_field, inc_pulse}, 32'd0);
    chk("arst_out", 32'(out_digits), 32'd0);
    chk("arst_blank", 32'(blank_mask), 32'd0);
    key_mode_n = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(30);
    chk("arst_no_inc", 32'(inc_cnt - inc0), 32'd0);
    chk("arst_final_out", 32'(out_digits), 32'(TOD));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
